mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single external memory port between instruction-cache line fills and data-side accesses. It sits between the fetch stage's fill engine, the data memory stage and the SRAM controller, using the same `REQ`/`RES` bus bundles on every side. The arbiter adds one cycle of arbitration latency from an idle port and holds a grant for a bounded burst so I$ line fills stream without thrashing. Data-side requests still get served within a bounded time.

## Interface
- MAX_BURST, 32: accepted transfers the owner may issue while the other master waits before the grant is forced over; minimum 1
- CNT_BITS, 16: width of statistics counters (only with MEM_ARB_STATS_EN)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- imem_req  in  `REQ  fetch fill request (A, R, W, WD, WBE)
- imem_res  out  `RES  fetch response (HOLD, RD)
- dmem_req  in  `REQ  data-side request
- dmem_res  out  `RES  data-side response
- mem_req  out  `REQ  to memory controller
- mem_res  in  `RES  from memory controller
- stat_i_grants, stat_d_grants, stat_d_wait  out  CNT_BITS each  grant and wait counters (MEM_ARB_STATS_EN only)

## Operation
- Master "active" = its R|W asserted. A transfer is accepted in a cycle where the owner is active and mem_res`HOLD=0.
- States: IDLE, OWN_I, OWN_D (registered owner). The `burst` counter has width clog2(MAX_BURST+1).
- IDLE: mem_req R=W=0, A/WD/WBE=0. Next state is OWN_D if dmem is active, else OWN_I if imem is active, else IDLE. D wins simultaneous requests. burst<=0.
- OWN_x: mem_req = x's request, combinationally. x_res`HOLD = mem_res`HOLD. The other master's HOLD = 1.
- Each accept increments burst, saturating at MAX_BURST.
- Release when the owner is inactive:
  - If the other master is active, switch directly to OWN_other and set burst<=0. No IDLE bubble.
  - Otherwise go to IDLE.
- Forced switch when an accept occurs with burst==MAX_BURST-1 (or more) and the other master is active. The next state is OWN_other and burst<=0. The preempted master sees HOLD=1 and re-arbitrates later with its request held.
- mem_res`RD is driven to both imem_res`RD and dmem_res`RD unmodified. Each master qualifies read data by its own accepted-last-cycle condition, so no routing register is needed.
- Writes (W) are arbitrated identically; no response beyond HOLD.
- A request held under HOLD must be kept stable by the master. The arbiter neither latches nor modifies it.

## Timing
- Reset (async assert): state=IDLE, burst=0, mem_req R=W=0 and all fields 0, imem_res`HOLD=dmem_res`HOLD=1, RD outputs follow mem_res`RD, stats=0.
- Reset release mid-transfer: any in-flight memory read data is discarded. The arbiter restarts in IDLE.
- Idle → first accept: minimum 2 cycles. Cycle 0 has the request seen with HOLD=1; cycle 1 is owned and passes through.
- Back-to-back streaming while owned: one accept per cycle when the memory does not hold.
- Read data is valid on RD in the cycle after accept, as the memory controller defines.
- Switch latency: the master losing the grant sees HOLD=1 starting the cycle after its last accept.
- A waiting master is granted within MAX_BURST owner accepts, plus memory HOLD cycles.
- No combinational path from mem_res`HOLD to mem_req.

## Configuration
- MEM_ARB_STATS_EN defined:
  - stat_i_grants increments on every entry into OWN_I.
  - stat_d_grants increments on every entry into OWN_D.
  - stat_d_wait increments each cycle dmem is active while dmem_res`HOLD=1.
  - All three counters wrap at 2^CNT_BITS and reset to 0.
- MEM_ARB_STATS_EN undefined: the stat ports and counters are absent. Arbitration behaviour is cycle-identical.

## Test plan
- Single dmem read at 0x100, mem HOLD=0 -> dmem HOLD=1 on cycle 0; mem_req A=0x100 R=1 on cycle 1; RD returned on cycle 2; IDLE on cycle 3 after R drops.
- imem and dmem request in the same cycle from IDLE -> OWN_D first; imem granted directly after dmem drops its request, with no idle cycle.
- imem 32-word fill, dmem active from fill word 3, MAX_BURST=8 -> exactly 8 imem accepts, then dmem owns; imem resumes at its 9th address with no address skipped or duplicated.
- mem HOLD=1 for 5 cycles during OWN_I -> imem HOLD=1 for those cycles, burst unchanged; with stats enabled, stat_d_wait counts dmem-waiting cycles exactly.
- dmem write (W=1, WBE=4'b0011) -> mem_req fields match dmem_req bit-for-bit; imem HOLD=1 throughout.
- Assert rst during OWN_I with a pending accept -> HOLD=1 on both ports and mem R=W=0 immediately (async); after release, the first grant takes 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I$ line fills and data accesses, with bounded bursts.
// Define MEM_ARB_STATS_EN to build the grant/wait statistics counters and their ports.
`ifndef MEM_ARB_BUS_DEFS
`define MEM_ARB_BUS_DEFS
// REQ bundle: {A[31:0], R, W, WD[31:0], WBE[3:0]}; RES bundle: {HOLD, RD[31:0]}
`define REQ  [69:0]
`define A    [69:38]
`define R    [37]
`define W    [36]
`define WD   [35:4]
`define WBE  [3:0]
`define RES  [32:0]
`define HOLD [32]
`define RD   [31:0]
`endif

module mem_arbiter #(
    parameter int MAX_BURST = 32
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int CNT_BITS  = 16
`endif
) (
    input  logic      clk,
    input  logic      rst,
    input  logic `REQ imem_req_i,
    output logic `RES imem_res_o,
    input  logic `REQ dmem_req_i,
    output logic `RES dmem_res_o,
    output logic `REQ mem_req_o,
    input  logic `RES mem_res_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_BITS-1:0] stat_i_grants_o,
    output logic [CNT_BITS-1:0] stat_d_grants_o,
    output logic [CNT_BITS-1:0] stat_d_wait_o
`endif
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_e;

    state_e        state_q;
    logic [BW-1:0] burst_q;

    logic   i_act;
    logic   d_act;
    logic   own_act;
    logic   oth_act;
    logic   accept;
    logic   burst_cap;
    logic   switch_req;
    logic   enter_i;
    logic   enter_d;
    state_e other_st;

    assign i_act = imem_req_i `R | imem_req_i `W;
    assign d_act = dmem_req_i `R | dmem_req_i `W;

    always_comb begin
        own_act  = 1'b0;
        oth_act  = 1'b0;
        other_st = IDLE;
        case (state_q)
            OWN_I: begin
                own_act  = i_act;
                oth_act  = d_act;
                other_st = OWN_D;
            end
            OWN_D: begin
                own_act  = d_act;
                oth_act  = i_act;
                other_st = OWN_I;
            end
            default: ;
        endcase
    end

    assign accept    = own_act & ~mem_res_i `HOLD;
    assign burst_cap = int'(burst_q) >= (MAX_BURST - 1);

    // Hand over either on release by the owner or when its burst allowance runs out.
    assign switch_req = oth_act & (~own_act | (accept & burst_cap));
    assign enter_d    = (state_q == IDLE) ? d_act : ((state_q == OWN_I) & switch_req);
    assign enter_i    = (state_q == IDLE) ? (i_act & ~d_act) : ((state_q == OWN_D) & switch_req);

    // Request path depends only on the registered owner, never on mem HOLD.
    always_comb begin
        mem_req_o  = '0;
        imem_res_o = {1'b1, mem_res_i `RD};
        dmem_res_o = {1'b1, mem_res_i `RD};
        case (state_q)
            OWN_I: begin
                mem_req_o         = imem_req_i;
                imem_res_o `HOLD  = mem_res_i `HOLD;
            end
            OWN_D: begin
                mem_req_o         = dmem_req_i;
                dmem_res_o `HOLD  = mem_res_i `HOLD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            case (state_q)
                OWN_I, OWN_D: begin
                    if (switch_req) begin
                        state_q <= other_st;
                        burst_q <= '0;
                    end else if (!own_act) begin
                        state_q <= IDLE;
                        burst_q <= '0;
                    end else if (accept && (int'(burst_q) < MAX_BURST)) begin
                        burst_q <= burst_q + BW'(1);
                    end
                end
                default: begin
                    burst_q <= '0;
                    if (enter_d) begin
                        state_q <= OWN_D;
                    end else if (enter_i) begin
                        state_q <= OWN_I;
                    end
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [CNT_BITS-1:0] i_grants_q;
    logic [CNT_BITS-1:0] d_grants_q;
    logic [CNT_BITS-1:0] d_wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grants_q <= '0;
            d_grants_q <= '0;
            d_wait_q   <= '0;
        end else begin
            if (enter_i) begin
                i_grants_q <= i_grants_q + CNT_BITS'(1);
            end
            if (enter_d) begin
                d_grants_q <= d_grants_q + CNT_BITS'(1);
            end
            if (d_act && dmem_res_o `HOLD) begin
                d_wait_q <= d_wait_q + CNT_BITS'(1);
            end
        end
    end

    assign stat_i_grants_o = i_grants_q;
    assign stat_d_grants_o = d_grants_q;
    assign stat_d_wait_o   = d_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against an owner/burst model.
module tb_mem_arbiter;
    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [69:0] imem_req, dmem_req, mem_req;
    logic [32:0] imem_res, dmem_res, mem_res;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] st_ig, st_dg, st_dw;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req_i (imem_req),
        .imem_res_o (imem_res),
        .dmem_req_i (dmem_req),
        .dmem_res_o (dmem_res),
        .mem_req_o  (mem_req),
        .mem_res_i  (mem_res)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_i_grants_o (st_ig),
        .stat_d_grants_o (st_dg),
        .stat_d_wait_o   (st_dw)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port, and how many transfers it got in this grant.
    int          owner = 0;   // 0 none, 1 imem, 2 dmem
    int          run   = 0;
    logic [15:0] exp_ig = '0, exp_dg = '0, exp_dw = '0;

    function automatic logic [69:0] mk(input logic [31:0] a, input logic r, input logic w,
                                       input logic [31:0] wd, input logic [3:0] be);
        return {a, r, w, wd, be};
    endfunction

    function automatic bit act(input logic [69:0] q);
        return q[37] | q[36];
    endfunction

    function automatic logic [69:0] rnd_req();
        int sel;
        sel = $urandom_range(1, 2);
        return mk($urandom, sel == 1, sel == 2, $urandom, 4'($urandom));
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner  = 0;
        run    = 0;
        exp_ig = '0;
        exp_dg = '0;
        exp_dw = '0;
    endtask

    task automatic settle();
        logic [69:0] em;
        logic        eih, edh;
        #4;
        em  = (owner == 1) ? imem_req : (owner == 2) ? dmem_req : '0;
        eih = (owner == 1) ? mem_res[32] : 1'b1;
        edh = (owner == 2) ? mem_res[32] : 1'b1;
        chk("mem_req", mem_req, em);
        chk("imem_hold", 70'(imem_res[32]), 70'(eih));
        chk("dmem_hold", 70'(dmem_res[32]), 70'(edh));
        chk("imem_rd", 70'(imem_res[31:0]), 70'(mem_res[31:0]));
        chk("dmem_rd", 70'(dmem_res[31:0]), 70'(mem_res[31:0]));
`ifdef MEM_ARB_STATS_EN
        chk("stat_i_grants", 70'(st_ig), 70'(exp_ig));
        chk("stat_d_grants", 70'(st_dg), 70'(exp_dg));
        chk("stat_d_wait", 70'(st_dw), 70'(exp_dw));
`endif
    endtask

    task automatic advance();
        bit ia, da, own_a, oth_a, acc;
        ia = act(imem_req);
        da = act(dmem_req);
        if (da && !(owner == 2 && !mem_res[32])) exp_dw++;
        if (owner == 0) begin
            if (da) begin
                owner = 2;
                exp_dg++;
            end else if (ia) begin
                owner = 1;
                exp_ig++;
            end
            run = 0;
        end else begin
            own_a = (owner == 1) ? ia : da;
            oth_a = (owner == 1) ? da : ia;
            acc   = own_a && !mem_res[32];
            if (acc) run++;
            if (oth_a && (!own_a || (acc && run >= MB))) begin
                owner = 3 - owner;
                run   = 0;
                if (owner == 1) exp_ig++; else exp_dg++;
            end else if (!own_a) begin
                owner = 0;
                run   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        imem_req = '0;
        dmem_req = '0;
        for (int k = 0; k < n; k++) begin
            mem_res = {1'b0, $urandom};
            settle();
            advance();
        end
    endtask

    initial begin
        int          idx, n_pre, resume_idx, n_i, budget;
        bit          d_seen, i_acc, d_acc;
        logic [31:0] rd;

        rst      = 1'b1;
        imem_req = '0;
        dmem_req = '0;
        mem_res  = {1'b0, 32'h1234_5678};
        settle();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single data read at 0x100
        dmem_req = mk(32'h100, 1'b1, 1'b0, '0, '0);
        settle();
        chk("rd_c0_dhold", 70'(dmem_res[32]), 70'(1'b1));
        advance();
        settle();
        chk("rd_c1_addr", 70'(mem_req[69:38]), 70'(32'h100));
        chk("rd_c1_r", 70'(mem_req[37]), 70'(1'b1));
        advance();
        dmem_req = '0;
        rd = 32'hCAFE_F00D;
        mem_res = {1'b0, rd};
        settle();
        chk("rd_c2_data", 70'(dmem_res[31:0]), 70'(rd));
        advance();
        settle();
        chk("rd_c3_idle", mem_req, 70'd0);
        advance();

        // Simultaneous requests: data first, then fetch with no idle bubble
        imem_req = mk(32'h2000, 1'b1, 1'b0, '0, '0);
        dmem_req = mk(32'h3000, 1'b1, 1'b0, '0, '0);
        settle();
        advance();
        settle();
        chk("sim_d_first", 70'(dmem_res[32]), 70'(1'b0));
        chk("sim_i_waits", 70'(imem_res[32]), 70'(1'b1));
        advance();
        dmem_req = '0;
        settle();
        advance();
        settle();
        chk("sim_i_next", 70'(imem_res[32]), 70'(1'b0));
        chk("sim_i_addr", 70'(mem_req[69:38]), 70'(32'h2000));
        advance();
        idle_cycles(2);

        // 32-word fill with data arriving from word 3
        idx = 0; n_pre = 0; resume_idx = -1; d_seen = 0; budget = 0;
        while (idx < 32 && budget < 200) begin
            imem_req = mk(32'h8000 + 32'(idx) * 4, 1'b1, 1'b0, '0, '0);
            dmem_req = (idx >= 3 && !d_seen) ? mk(32'h4000, 1'b1, 1'b0, '0, '0) : '0;
            mem_res  = {1'b0, $urandom};
            settle();
            if (act(dmem_req) && !dmem_res[32]) d_seen = 1;
            if (!imem_res[32]) begin
                if (!d_seen) n_pre++;
                else if (resume_idx < 0) resume_idx = idx;
                idx++;
            end
            advance();
            budget++;
        end
        chk("fill_words", 70'(idx), 70'd32);
        chk("fill_accepts_before_d", 70'(n_pre), 70'(MB));
        chk("fill_resume_idx", 70'(resume_idx), 70'(MB));
        idle_cycles(2);

        // Memory stalls during a fetch grant while data waits
        imem_req = mk(32'h5000, 1'b1, 1'b0, '0, '0);
        mem_res  = {1'b0, $urandom};
        settle();
        advance();
        settle();
        n_i = imem_res[32] ? 0 : 1;
        advance();
        imem_req = mk(32'h5004, 1'b1, 1'b0, '0, '0);
        dmem_req = mk(32'h5100, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            mem_res = {1'b1, $urandom};
            settle();
            chk("stall_ihold", 70'(imem_res[32]), 70'(1'b1));
            advance();
        end
        d_seen = 0; budget = 0;
        while (!d_seen && budget < 40) begin
            mem_res = {1'b0, $urandom};
            settle();
            if (!dmem_res[32]) d_seen = 1;
            if (!imem_res[32]) begin
                n_i++;
                imem_req = mk(32'h5000 + 32'(n_i) * 4, 1'b1, 1'b0, '0, '0);
            end
            advance();
            budget++;
        end
        chk("stall_d_granted", 70'(d_seen), 70'(1'b1));
        chk("stall_burst_accepts", 70'(n_i), 70'(MB));
        idle_cycles(3);

        // Data write while fetch is also requesting
        imem_req = mk(32'h7000, 1'b1, 1'b0, '0, '0);
        dmem_req = mk(32'hA5A5_0040, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        for (int k = 0; k < 3; k++) begin
            mem_res = {(k == 1), $urandom};
            settle();
            chk("wr_ihold", 70'(imem_res[32]), 70'(1'b1));
            if (k > 0) chk("wr_fields", mem_req, dmem_req);
            advance();
        end
        idle_cycles(4);

        // Asynchronous reset in the middle of a fetch grant
        imem_req = mk(32'h6000, 1'b1, 1'b0, '0, '0);
        mem_res  = {1'b0, $urandom};
        settle();
        advance();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ihold", 70'(imem_res[32]), 70'(1'b1));
        chk("arst_dhold", 70'(dmem_res[32]), 70'(1'b1));
        chk("arst_mem_req", mem_req, 70'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("arst_c0_hold", 70'(imem_res[32]), 70'(1'b1));
        advance();
        settle();
        chk("arst_c1_grant", 70'(imem_res[32]), 70'(1'b0));
        advance();
        idle_cycles(2);

        // Randomized traffic from both masters with random memory stalls
        i_acc = 1; d_acc = 1;
        for (int c = 0; c < 400; c++) begin
            if (i_acc || !act(imem_req)) imem_req = ($urandom_range(2) != 0) ? rnd_req() : '0;
            if (d_acc || !act(dmem_req)) dmem_req = ($urandom_range(2) != 0) ? rnd_req() : '0;
            mem_res = {($urandom_range(3) == 0), $urandom};
            settle();
            i_acc = act(imem_req) && !imem_res[32];
            d_acc = act(dmem_req) && !dmem_res[32];
            advance();
        end
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
